prog_loader: RTL and testbench

- Writer side of the CPU instruction-fetch path: receives a byte-stream program image and writes it as 16-bit words into instruction memory.
- Sits between a byte source (UART receiver or bench driver) and the instruction memory write port.
- Holds the CPU (brain) in reset through cpu_hold until a complete, checksum-verified image has been written.

---
 rtl/prog_loader.sv | 200 ++++++++++++++++++++
 tb/tb_prog_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader
// Receives a big-endian byte-stream program image and writes it into
// instruction memory as 16-bit words. The CPU is held in reset until a
// complete image with a matching checksum has been written.
//
// Stream layout: CNT_HI, CNT_LO (word count N), 2N data bytes (each word
// high byte first), then one checksum byte equal to the 8-bit sum of the
// data bytes.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-high reset
//   start      - begin a load (honoured in IDLE, DONE, ERR)
//   abort      - return to IDLE from any state (wins over start)
//   in_data    - stream byte
//   in_valid   - in_data valid
//   in_ready   - loader accepts a byte this cycle
//   imem_we    - instruction memory write strobe (one cycle per word)
//   imem_addr  - word address of the write
//   imem_wdata - word data of the write
//   cpu_hold   - 1 keeps the CPU in reset
//   done       - image loaded and verified
//   error      - load failed (oversize count or bad checksum)
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t              r_state;
  logic [15:0]         r_cnt;
  logic [ADDR_W:0]     r_wcnt;
  logic [7:0]          r_sum;
  logic [7:0]          r_hi;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_wdata;
  logic                r_ready;
  logic                r_hold;
  logic                r_done;
  logic                r_error;

  state_t              w_state;
  logic [15:0]         w_cnt;
  logic [ADDR_W:0]     w_wcnt;
  logic [7:0]          w_sum;
  logic [7:0]          w_hi;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [15:0]         w_wdata;
  logic                w_ready;
  logic                w_hold;
  logic                w_done;
  logic                w_error;
  logic                w_xfer;
  logic [15:0]         w_n;
  logic                w_last;

  assign in_ready   = r_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_hold   = r_hold;
  assign done       = r_done;
  assign error      = r_error;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_wcnt  = r_wcnt;
    w_sum   = r_sum;
    w_hi    = r_hi;
    w_we    = 1'b0;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_xfer  = in_valid & r_ready;
    w_n     = {r_cnt[15:8], in_data};
    // Compare at 17 bits so a counter of ADDR_W+1 bits never truncates N.
    w_last  = (17'(r_wcnt) + 17'd1) == {1'b0, r_cnt};

    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          w_state = S_CNT_HI;
          w_wcnt  = '0;
          w_sum   = '0;
        end
      end
      S_CNT_HI: begin
        if (w_xfer) begin
          w_cnt[15:8] = in_data;
          w_state     = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (w_xfer) begin
          w_cnt = w_n;
          if (w_n == 16'd0)
            w_state = S_CHK;
          else if ({1'b0, w_n} > (17'd1 << ADDR_W))
            w_state = S_ERR;
          else
            w_state = S_DAT_HI;
        end
      end
      S_DAT_HI: begin
        if (w_xfer) begin
          w_hi    = in_data;
          w_sum   = r_sum + in_data;
          w_state = S_DAT_LO;
        end
      end
      S_DAT_LO: begin
        if (w_xfer) begin
          w_sum   = r_sum + in_data;
          // Write issues from the output register on the next cycle, so the
          // stream keeps flowing one byte per clock.
          w_we    = 1'b1;
          w_addr  = r_wcnt[ADDR_W-1:0];
          w_wdata = {r_hi, in_data};
          w_wcnt  = r_wcnt + 1'b1;
          w_state = w_last ? S_CHK : S_DAT_HI;
        end
      end
      S_CHK: begin
        if (w_xfer)
          w_state = (in_data == r_sum) ? S_DONE : S_ERR;
      end
      default: w_state = S_IDLE;
    endcase

    // abort overrides everything, including a write scheduled for this edge.
    if (abort) begin
      w_state = S_IDLE;
      w_we    = 1'b0;
    end

    // Status outputs are registered copies of the decoded next state.
    w_ready = (w_state == S_CNT_HI) || (w_state == S_CNT_LO) ||
              (w_state == S_DAT_HI) || (w_state == S_DAT_LO) ||
              (w_state == S_CHK);
    w_done  = (w_state == S_DONE);
    w_error = (w_state == S_ERR);
    w_hold  = (w_state != S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wcnt  <= '0;
      r_sum   <= '0;
      r_hi    <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ready <= 1'b0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_wcnt  <= w_wcnt;
      r_sum   <= w_sum;
      r_hi    <= w_hi;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_ready <= w_ready;
      r_hold  <= w_hold;
      r_done  <= w_done;
      r_error <= w_error;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// Directed and randomized program-image loads against a reference model
// that derives the expected writes and final status straight from the
// stream format rules (count, data words, modulo-256 checksum).
module tb_prog_loader;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              reset;
  logic              start;
  logic              abort;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  int n_checks = 0;
  int n_errors = 0;
  int stalls   = 0;
  int n_loads  = 0;

  logic [15:0] img[$];
  logic [23:0] wq[$];

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every write strobe away from the active edge.
  always @(negedge clk) begin
    if (imem_we === 1'b1)
      wq.push_back({imem_addr, imem_wdata});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] img_sum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++)
      s += int'(img[i][15:8]) + int'(img[i][7:0]);
    return 8'(s % 256);
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte; returns at the negedge after it transferred.
  task automatic send_byte(input logic [7:0] b);
    int waitc = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && waitc < 50) begin
      @(posedge clk);
      @(negedge clk);
      waitc++;
      stalls++;
    end
    if (waitc >= 50) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic run_load(input int n, input logic [7:0] chk);
    logic exp_done;
    int   exp_writes;
    int   lim;
    logic [15:0] nn;
    wq.delete();
    stalls = 0;
    nn = 16'(n);
    pulse_start();
    check("ready_after_start", 32'(in_ready), 32'd1);
    check("hold_after_start", 32'(cpu_hold), 32'd1);
    send_byte(nn[15:8]);
    send_byte(nn[7:0]);
    if (n <= (1 << ADDR_W)) begin
      for (int i = 0; i < n; i++) begin
        send_byte(img[i][15:8]);
        send_byte(img[i][7:0]);
      end
      send_byte(chk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    exp_done   = (n <= (1 << ADDR_W)) && (chk == img_sum(n));
    exp_writes = (n <= (1 << ADDR_W)) ? n : 0;
    check("stalls", 32'(stalls), 32'd0);
    check("write_count", 32'(wq.size()), 32'(exp_writes));
    lim = (wq.size() < exp_writes) ? wq.size() : exp_writes;
    for (int i = 0; i < lim; i++)
      check("write_word", 32'(wq[i]), 32'({8'(i), img[i]}));
    check("done", 32'(done), 32'(exp_done));
    check("error", 32'(error), 32'(!exp_done));
    check("cpu_hold", 32'(cpu_hold), 32'(!exp_done));
    check("ready_idle", 32'(in_ready), 32'd0);
    n_loads++;
    $display("load %0d: N=%0d chk=%02h writes=%0d done=%0b error=%0b",
             n_loads, n, chk, wq.size(), done, error);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] s;
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    #1;
    check_reset_values("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(in_ready), 32'd0);

    // Two-word image with good and with corrupted checksum.
    img.delete();
    img.push_back(16'h1234);
    img.push_back(16'hABCD);
    s = img_sum(2);
    run_load(2, s);
    run_load(2, s + 8'd1);

    // Empty image, then an oversize count.
    img.delete();
    run_load(0, 8'h00);
    run_load(257, 8'h00);

    // Full memory, data word i = i, one byte per cycle.
    img.delete();
    for (int i = 0; i < 256; i++) img.push_back(16'(i));
    run_load(256, img_sum(256));

    // Random images, checksum randomly good or bad.
    for (int k = 0; k < 6; k++) begin
      img.delete();
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) img.push_back(16'($urandom));
      s = img_sum(n);
      if ($urandom_range(0, 1) == 1)
        s = s + 8'($urandom_range(1, 255));
      run_load(n, s);
    end

    // Abort on the cycle word 1's low byte transfers.
    wq.delete();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    in_data  = 8'hCD;
    in_valid = 1'b1;
    abort    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_ready", 32'(in_ready), 32'd0);
    check("abort_hold", 32'(cpu_hold), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_error", 32'(error), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_writes", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) check("abort_word0", 32'(wq[0]), 32'h00_1234);
    $display("abort during word 1: writes=%0d ready=%0b hold=%0b", wq.size(), in_ready, cpu_hold);

    // start together with abort stays in IDLE.
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("startabort_ready", 32'(in_ready), 32'd0);
    check("startabort_hold", 32'(cpu_hold), 32'd1);
    $display("start+abort: ready=%0b hold=%0b", in_ready, cpu_hold);

    // Reset between edges while in DAT_HI.
    wq.delete();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_wdata", 32'(imem_wdata), 32'h1122);
    #2 reset = 1'b1;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    reset = 1'b0;
    wq.delete();
    repeat (3) @(negedge clk);
    check("post_reset_ready", 32'(in_ready), 32'd0);
    check("post_reset_hold", 32'(cpu_hold), 32'd1);
    check("post_reset_writes", 32'(wq.size()), 32'd0);
    $display("reset mid-load: ready=%0b hold=%0b writes=%0d", in_ready, cpu_hold, wq.size());

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
